// File: rtl/pipe_pkg.sv
// Shared constants and types for the elastic pipeline stage register.
package pipe_pkg;

    localparam int          PC_W             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    // Occupancy of one stage: 0, 1, or 2 when the skid entry is present
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between a producer/consumer pair and one pipeline stage register.
interface pipe_stage_reg_if #(parameter int WIDTH = 32);
    import pipe_pkg::*;

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    occ_t             count;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/pipe_slot.sv
// One valid+data register. A bubble keeps the PC field and zeroes the payload below it,
// and it takes priority over load, which in turn takes priority over clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    function automatic logic [WIDTH-1:0] with_pc(input logic [PC_W-1:0] pc);
        logic [WIDTH-1:0] r;
        r = '0;
        r[WIDTH-1 -: PC_W] = pc;
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= with_pc(RESET_PC);
        end else if (bubble) begin
            valid <= 1'b0;
            q     <= with_pc(q[WIDTH-1 -: PC_W]);
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with valid/ready handshake, flush to bubble and
// an optional skid entry enabled by the PIPE_SKID_EN macro.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_reg_if.slave    bus
);

    logic             main_valid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic             main_load;
    logic             main_clear;
    logic             accept;
    logic             pop;

    assign pop = main_valid && bus.out_ready;

`ifdef PIPE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_q;
    logic             skid_load;
    logic             skid_clear;

    // Ready comes straight from a register, so there is no out_ready -> in_ready path.
    assign bus.in_ready = !skid_valid;
    assign accept       = bus.in_valid && !skid_valid;

    // Main takes the oldest pending bundle: the skid entry if present, otherwise the input.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = bus.in_data;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_load  = (!main_valid && accept) || (pop && (skid_valid || accept));
        main_d     = skid_valid ? skid_q : bus.in_data;
        main_clear = pop && !main_load;
        skid_load  = accept && main_valid && !pop;
        skid_clear = pop && skid_valid;
    end

    pipe_slot #(.WIDTH(WIDTH), .RESET_PC(32'h0000_0000)) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .bubble (bus.flush),
        .d      (bus.in_data),
        .valid  (skid_valid),
        .q      (skid_q)
    );

    assign bus.count = occ_t'({1'b0, main_valid}) + occ_t'({1'b0, skid_valid});
`else
    assign bus.in_ready = !main_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d     = bus.in_data;
        main_load  = accept;
        main_clear = pop && !accept;
    end

    assign bus.count = occ_t'({1'b0, main_valid});
`endif

    pipe_slot #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .bubble (bus.flush),
        .d      (main_d),
        .valid  (main_valid),
        .q      (main_q)
    );

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register for the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries). Carries a WIDTH-bit bundle whose top 32 bits are the PC field, with a valid/ready handshake, stall by back-pressure, synchronous flush to a bubble, and an optional 2-entry skid buffer. It replaces the fixed always-write stage register, which cannot hold data or insert bubbles.

## Interface
- WIDTH, 32, bundle width; must be >= 32; bits [WIDTH-1:WIDTH-32] are the PC field
- RESET_PC, 32'h0000_3000, PC field value after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- in_data  in  WIDTH  upstream bundle
- out_valid  out  1  out_data holds a live bundle
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- out_data  out  WIDTH  held bundle
- count  out  2  occupancy, 0..2 (max 1 without skid)

## Operation
- Reset (async): out_valid=0, count=0, in_ready=1, out_data={RESET_PC, (WIDTH-32)'b0}, skid entry invalid and zeroed.
- Accept: on in_valid && in_ready, bundle captured; never dropped or duplicated except by flush.
- Hold: when out_valid && !out_ready, out_data and out_valid stay bit-for-bit stable.
- Pop: on out_valid && out_ready, entry leaves; if a newer entry exists (input same cycle or skid), it replaces out_data next cycle.
- Order: strict FIFO between input and output.
- Flush (priority over everything except rst): next cycle out_valid=0, count=0, skid invalid, in_ready=1; out_data PC field kept, lower WIDTH-32 bits cleared to 0 (NOP bubble). An input handshake in the flush cycle is consumed and discarded; an output handshake in the flush cycle counts as delivered.
- out_valid low: out_data content is don't-care to consumers but must equal the bubble value after flush/reset.
- Simultaneous accept and pop with count=1: count stays 1, out_data takes new bundle.

## Timing
- Latency in_data -> out_data: 1 cycle. Throughput: 1 bundle/cycle with out_ready held high.
- Without skid: in_ready = !out_valid || out_ready, combinational from out_ready.
- With skid: in_ready is a register output (= skid empty); no combinational in->out ready path. Skid fills when an entry is accepted while main is full and out_ready=0; in_ready falls the following cycle. Skid drains into main on the cycle main pops; in_ready rises the cycle after.
- count updates on the same edge as the handshakes.

## Configuration
- PIPE_SKID_EN defined: 2-entry (main + skid) stage, registered in_ready, count reaches 2.
- PIPE_SKID_EN undefined: single-entry stage, combinational in_ready, count in {0,1}, skid logic absent.
- Reset, flush, ordering and latency identical in both builds.

## Structure
- Package pipe_pkg: RESET_PC_DEFAULT = 32'h0000_3000, NOP_WORD = 32'h0000_0000, PC_W = 32, occupancy type (2-bit).
- One sub-module pipe_slot: single valid+data register with load/clear/bubble controls; instantiated once for main, once more for skid under PIPE_SKID_EN.

## Test plan
- Reset mid-traffic with count=1, WIDTH=64 -> same cycle out_valid=0, out_data=64'h0000_3000_0000_0000, count=0, in_ready=1.
- Stream 0x00400000..0x0040001C (PC field), out_ready=1 -> each appears exactly 1 cycle later, one per cycle, in order.
- Stall: load A, hold out_ready=0 for 5 cycles -> out_data=A constant; without skid in_ready=0; with skid second bundle B accepted, count=2, in_ready=0 next cycle; release -> A then B on consecutive cycles.
- Flush with count=2 (skid build), out_data PC 0x00400010 -> next cycle out_valid=0, count=0, out_data={0x00400010, zeros}; bundle offered in flush cycle never appears.
- Accept and pop same cycle at count=1 -> count stays 1, out_data = new bundle, no bubble.
- Random valid/ready, both builds -> scoreboard shows no loss, duplication or reordering; out_data stable whenever out_valid && !out_ready.
